// File: rtl/fir_control_param.sv
// fir_control_param: FIR sequencer (load -> MAC -> add tree -> done) with tap-gated MAC enables,
// configurable add-tree latency, MAC watchdog and tap_num range checking.
module fir_control_param #(
  parameter int NUM_MAC      = 4,
  parameter int TAPS_PER_MAC = 8,
  parameter int TAP_W        = 6,
  parameter int ADD_LAT      = 2,
  parameter int MAC_TIMEOUT  = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               configuration,
  input  logic [TAP_W-1:0]   tap_num,
  input  logic               mac_done,
  output logic               done,
  output logic               load_enable,
  output logic               add_enable,
  output logic               config_enable,
  output logic [NUM_MAC-1:0] mac_enable,
  output logic               busy,
  output logic               cfg_err,
  output logic               timeout_err
);
  localparam int MAX_TAPS = NUM_MAC * TAPS_PER_MAC;
  localparam int MW       = $clog2(MAC_TIMEOUT);
  localparam int AW       = $clog2(ADD_LAT + 1);
  typedef enum logic [2:0] {IDLE, CONFIG, LOAD, MAC, ADD, DONE} state_t;
  state_t             state, state_nx;
  logic [TAP_W-1:0]   taps;
  logic [MW-1:0]      mac_cnt;
  logic [AW-1:0]      add_cnt;
  logic [NUM_MAC-1:0] mac_mask;
  logic               tap_ok, mac_last, add_last;
  assign tap_ok   = tap_num != '0 && tap_num <= TAP_W'(MAX_TAPS);
  assign mac_last = mac_cnt == MW'(MAC_TIMEOUT - 1);
  assign add_last = add_cnt == AW'(ADD_LAT - 1);
  // MAC unit i is needed whenever the tap count reaches into its slice of taps
  for (genvar i = 0; i < NUM_MAC; i++) begin : g_mask
    assign mac_mask[i] = taps > TAP_W'(i * TAPS_PER_MAC);
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = configuration ? CONFIG : enable ? LOAD : IDLE;
      CONFIG:  state_nx = IDLE;
      LOAD:    state_nx = MAC;
      MAC:     state_nx = mac_done ? ADD : mac_last ? IDLE : MAC;
      ADD:     state_nx = add_last ? DONE : ADD;
      DONE:    state_nx = enable ? LOAD : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      taps        <= TAP_W'(MAX_TAPS);
      mac_cnt     <= '0;
      add_cnt     <= '0;
      cfg_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      if (state == CONFIG && tap_ok) taps <= tap_num;
      mac_cnt     <= state == MAC ? mac_cnt + 1'b1 : '0;
      add_cnt     <= state == ADD ? add_cnt + 1'b1 : '0;
      cfg_err     <= state == CONFIG && !tap_ok;
      timeout_err <= state == MAC && !mac_done && mac_last;
    end
  end
  assign done          = state == DONE;
  assign load_enable   = state == LOAD;
  assign add_enable    = state == ADD;
  assign config_enable = state == CONFIG;
  assign mac_enable    = state == MAC ? mac_mask : '0;
  assign busy          = state != IDLE;
endmodule

// File: tb/tb_fir_control_param.sv
// tb_fir_control_param: directed stimulus pushes expected sample/error events; a negedge monitor pops and checks them.
`timescale 1ns/1ps
module tb_fir_control_param;
  logic       clk = 0, rst_n = 0, enable = 0, configuration = 0, mac_done = 0;
  logic [5:0] tap_num = 0;
  logic       done, load_enable, add_enable, config_enable, busy, cfg_err, timeout_err;
  logic [3:0] mac_enable;
  fir_control_param dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .configuration(configuration), .tap_num(tap_num),
    .mac_done(mac_done), .done(done), .load_enable(load_enable), .add_enable(add_enable),
    .config_enable(config_enable), .mac_enable(mac_enable), .busy(busy), .cfg_err(cfg_err),
    .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  typedef struct {int kind; int mac; int m; int gap;} exp_t;
  exp_t q[$];
  int checks = 0, failures = 0, mac_lat = 0, rcnt = 0;
  int cyc = 0, last_done = -1000, mentry = 0, mcnt = 0, acnt = 0, lcnt = 0, gap = 0, mac_v = 0;
  bit in_s = 0, prev_load = 0, busy_ok = 1, cfg_quiet = 1, mac_stable = 1;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (mac_enable != 0) begin
      rcnt++;
      mac_done = mac_lat != 0 && rcnt == mac_lat;
    end else begin
      rcnt = 0;
      mac_done = 0;
    end
  end
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      in_s = 0;
      prev_load = 0;
    end else begin
      if (load_enable && prev_load) lcnt++;
      else if (load_enable) begin
        in_s = 1; lcnt = 1; mcnt = 0; acnt = 0; mac_v = 0;
        busy_ok = 1; cfg_quiet = 1; mac_stable = 1; gap = cyc - last_done;
      end
      prev_load = load_enable;
      if (in_s && !timeout_err) begin
        if (!busy) busy_ok = 0;
        if (config_enable) cfg_quiet = 0;
        if (mac_enable != 0) begin
          if (mcnt == 0) begin mac_v = int'(mac_enable); mentry = cyc; end
          else if (int'(mac_enable) != mac_v) mac_stable = 0;
          mcnt++;
        end
        if (add_enable) acnt++;
      end
      if (done || timeout_err || cfg_err) begin
        if (q.size() == 0) chk("unexpected_event", {29'd0, done, timeout_err, cfg_err}, 0);
        else begin
          e = q.pop_front();
          chk("kind", done ? 0 : timeout_err ? 1 : 2, e.kind);
          if (e.kind == 0 && done) begin
            chk("mac_enable", mac_v, e.mac);
            chk("mac_stable", int'(mac_stable), 1);
            chk("mac_cycles", mcnt, e.m);
            chk("add_cycles", acnt, 2);
            chk("load_cycles", lcnt, 1);
            chk("busy_high", int'(busy_ok), 1);
            chk("cfg_ignored", int'(cfg_quiet), 1);
            if (e.gap >= 0) chk("done_to_load", gap, e.gap);
          end
          if (e.kind == 1 && timeout_err) begin
            chk("to_mac_enable", mac_v, e.mac);
            chk("to_delay", cyc - mentry, e.m);
            chk("to_idle", int'(busy), 0);
          end
        end
        if (done) last_done = cyc;
        if (done || timeout_err) in_s = 0;
      end
    end
  end
  task automatic drain();
    for (int c = 0; c < 300 && q.size() != 0; c++) @(negedge clk);
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
    repeat (3) @(negedge clk);
  endtask
  task automatic cfg(input int v, input bit bad);
    @(negedge clk);
    configuration = 1;
    tap_num = 6'(v);
    if (bad) q.push_back('{2, 0, 0, -1});
    @(negedge clk);
    configuration = 0;
    drain();
  endtask
  task automatic sample(input int lat, input int mac);
    mac_lat = lat;
    @(negedge clk);
    enable = 1;
    q.push_back('{0, mac, lat, -1});
    @(negedge clk);
    enable = 0;
    drain();
  endtask
  task automatic back_to_back(input int lat, input int mac);
    mac_lat = lat;
    @(negedge clk);
    enable = 1;
    for (int i = 0; i < 3; i++) q.push_back('{0, mac, lat, i == 0 ? -1 : 1});
    @(negedge clk);
    configuration = 1;
    tap_num = 6'd3;
    for (int c = 0; c < 100; c++) begin
      if (q.size() <= 1) break;
      @(posedge clk);
    end
    @(negedge clk);
    enable = 0;
    configuration = 0;
    drain();
  endtask
  initial begin
    #12 chk("reset_outs", {done, load_enable, add_enable, config_enable, mac_enable, busy, cfg_err, timeout_err}, 0);
    @(negedge clk);
    rst_n = 1;
    cfg(11, 0);
    sample(2, 4'b0011);
    cfg(32, 0);
    sample(2, 4'b1111);
    sample(3, 4'b1111);
    sample(1, 4'b1111);
    sample(64, 4'b1111);
    back_to_back(2, 4'b1111);
    mac_lat = 0;
    @(negedge clk);
    enable = 1;
    q.push_back('{1, 4'b1111, 64, -1});
    @(negedge clk);
    enable = 0;
    drain();
    cfg(11, 0);
    cfg(0, 1);
    cfg(40, 1);
    sample(2, 4'b0011);
    mac_lat = 0;
    @(negedge clk);
    enable = 1;
    @(negedge clk);
    enable = 0;
    for (int c = 0; c < 20 && mac_enable == 0; c++) @(negedge clk);
    chk("rst_pre_mac", int'(mac_enable), 4'b0011);
    repeat (5) @(posedge clk);
    #2 rst_n = 0;
    #1 chk("rst_mid_outs", {done, load_enable, add_enable, config_enable, mac_enable, busy, cfg_err, timeout_err}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    tap_num = 6'd11;
    sample(2, 4'b1111);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
